// File: rtl/cc_stream_pkg.sv
// rtl/cc_stream_pkg.sv - shared stream helpers: lane counter width and lane-index type.
package cc_stream_pkg;

    localparam int LaneIdxW = 8;

    typedef logic [LaneIdxW-1:0] lane_idx_t;

    function automatic int cnt_width(input int ratio);
        int w;
        w = $clog2(ratio);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stream_upsizer.sv
// rtl/stream_upsizer.sv - packs Ratio narrow beats into one registered wide word.
// STREAM_UPSIZER_LAST_EN adds last_i/last_o for early word closure with partial strobes.
module stream_upsizer
    import cc_stream_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int Ratio     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [DataWidth-1:0]       data_i,
`ifdef STREAM_UPSIZER_LAST_EN
    input  logic                       last_i,
`endif
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [DataWidth*Ratio-1:0] data_o,
    output logic [Ratio-1:0]           strb_o
`ifdef STREAM_UPSIZER_LAST_EN
    ,
    output logic                       last_o
`endif
);

    localparam int CntW = cnt_width(Ratio);

    typedef logic [Ratio-1:0][DataWidth-1:0] word_t;
    typedef logic [Ratio-2:0][DataWidth-1:0] acc_t;

    if (Ratio < 2 || DataWidth < 1 || Ratio > (1 << LaneIdxW)) begin : g_param_check
        $error("stream_upsizer: illegal parameters (need Ratio>=2, DataWidth>=1)");
    end

    logic [CntW-1:0]  cnt_q, cnt_d;
    acc_t             acc_q, acc_d;
    logic             valid_q, valid_d;
    word_t            data_q, data_d;
    logic [Ratio-1:0] strb_q, strb_d;
`ifdef STREAM_UPSIZER_LAST_EN
    logic             last_q, last_d;
`endif

    logic      last_in;
    logic      completing;
    logic      accept;
    logic      out_fire;
    lane_idx_t cnt_lane;

`ifdef STREAM_UPSIZER_LAST_EN
    assign last_in = last_i;
`else
    assign last_in = 1'b0;
`endif

    assign cnt_lane   = lane_idx_t'(cnt_q);
    assign completing = (cnt_q == CntW'(Ratio - 1)) || last_in;
    // Only a completing beat needs room in the output register; fills never stall.
    assign ready_o    = !rst_i && (!completing || !valid_q || ready_i);
    assign accept     = valid_i && ready_o;
    assign out_fire   = valid_q && ready_i;

    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        valid_d = valid_q;
        data_d  = data_q;
        strb_d  = strb_q;
`ifdef STREAM_UPSIZER_LAST_EN
        last_d  = last_q;
`endif
        if (accept && completing) begin
            valid_d = 1'b1;
            cnt_d   = '0;
            data_d  = '0;
            strb_d  = '0;
            for (int k = 0; k < Ratio - 1; k++) begin
                if (lane_idx_t'(k) < cnt_lane) begin
                    data_d[k] = acc_q[k];
                end
            end
            for (int k = 0; k < Ratio; k++) begin
                if (lane_idx_t'(k) == cnt_lane) begin
                    data_d[k] = data_i;
                end
                strb_d[k] = (lane_idx_t'(k) <= cnt_lane);
            end
`ifdef STREAM_UPSIZER_LAST_EN
            last_d = last_in;
`endif
        end else if (out_fire) begin
            valid_d = 1'b0;
        end

        if (accept && !completing) begin
            for (int k = 0; k < Ratio - 1; k++) begin
                if (lane_idx_t'(k) == cnt_lane) begin
                    acc_d[k] = data_i;
                end
            end
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
`ifdef STREAM_UPSIZER_LAST_EN
            last_q  <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
`ifdef STREAM_UPSIZER_LAST_EN
            last_q  <= last_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign strb_o  = strb_q;
`ifdef STREAM_UPSIZER_LAST_EN
    assign last_o  = last_q;
`endif

endmodule

// File: tb/tb_stream_upsizer.sv
// tb/tb_stream_upsizer.sv - self-checking bench for stream_upsizer (DataWidth=8, Ratio=4).
module tb_stream_upsizer;

    localparam int DW = 8;
    localparam int R  = 4;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b0;
    logic [DW-1:0] data_i  = '0;
    logic          ready_o;
    logic          valid_o;
    logic [DW*R-1:0] data_o;
    logic [R-1:0]  strb_o;
`ifdef STREAM_UPSIZER_LAST_EN
    logic          last_i  = 1'b0;
    logic          last_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_upsizer #(.DataWidth(DW), .Ratio(R)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
`ifdef STREAM_UPSIZER_LAST_EN
        .last_i  (last_i),
`endif
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .strb_o  (strb_o)
`ifdef STREAM_UPSIZER_LAST_EN
        ,
        .last_o  (last_o)
`endif
    );

    // Reference model: collect accepted beats, emit a word every R beats or on last.
    typedef struct packed {
        logic [DW*R-1:0] data;
        logic [R-1:0]    strb;
        logic            last;
    } exp_t;

    logic [DW-1:0]   part_q[$];
    exp_t            exp_q[$];
    exp_t            mon_w;
    exp_t            got_w;
    logic            mon_last;
    bit              hold_prev = 1'b0;
    logic [DW*R-1:0] held_data;
    logic [R-1:0]    held_strb;
    logic            held_last;
    logic            cur_last;

    always @(negedge clk) begin
`ifdef STREAM_UPSIZER_LAST_EN
        mon_last = last_i;
        cur_last = last_o;
`else
        mon_last = 1'b0;
        cur_last = 1'b0;
`endif
        if (rst) begin
            part_q.delete();
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checks++;
                if (valid_o !== 1'b1 || data_o !== held_data || strb_o !== held_strb || cur_last !== held_last) begin
                    failures++;
                    $display("FAIL hold_stable: valid=%b data=%h strb=%h last=%b, required valid=1 data=%h strb=%h last=%b",
                             valid_o, data_o, strb_o, cur_last, held_data, held_strb, held_last);
                end
            end
            if (valid_o && ready_i) begin
                checks++;
                got_w = '{data: data_o, strb: strb_o, last: cur_last};
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: data=%h strb=%h, required no word", data_o, strb_o);
                end else begin
                    mon_w = exp_q.pop_front();
                    if (got_w !== mon_w) begin
                        failures++;
                        $display("FAIL word_content: data=%h strb=%h last=%b, required data=%h strb=%h last=%b",
                                 got_w.data, got_w.strb, got_w.last, mon_w.data, mon_w.strb, mon_w.last);
                    end
                end
            end
            if (valid_i && ready_o) begin
                part_q.push_back(data_i);
                if (part_q.size() == R || mon_last) begin
                    mon_w = '0;
                    for (int k = 0; k < part_q.size(); k++) begin
                        mon_w.data[k*DW +: DW] = part_q[k];
                    end
                    mon_w.strb = R'((1 << part_q.size()) - 1);
                    mon_w.last = mon_last;
                    exp_q.push_back(mon_w);
                    part_q.delete();
                end
            end
            hold_prev = valid_o && !ready_i;
            held_data = data_o;
            held_strb = strb_o;
            held_last = cur_last;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b, required 0", ready_o); end
        checks++;
        if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b, required 0", valid_o); end
        checks++;
        if (data_o !== '0 || strb_o !== '0) begin
            failures++; $display("FAIL reset_data_strb: got %h/%h, required 0/0", data_o, strb_o);
        end
`ifdef STREAM_UPSIZER_LAST_EN
        checks++;
        if (last_o !== 1'b0) begin failures++; $display("FAIL reset_last: got %b, required 0", last_o); end
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b, required 1", ready_o); end
        checks++;
        if (valid_o !== 1'b0 || strb_o !== '0) begin
            failures++; $display("FAIL post_reset_out: valid=%b strb=%h, required 0/0", valid_o, strb_o);
        end
    endtask

    task automatic test_full_word();
        logic [DW-1:0] beats [R];
        beats = '{8'h11, 8'h22, 8'h33, 8'h44};
        ready_i = 1'b1;
        for (int i = 0; i < R; i++) begin
            @(posedge clk);
            #1 valid_i = 1'b1; data_i = beats[i];
        end
        @(posedge clk);
        #1 valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 32'h44332211 || strb_o !== 4'hF) begin
            failures++;
            $display("FAIL full_word: valid=%b data=%h strb=%h, required 1/44332211/f", valid_o, data_o, strb_o);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin failures++; $display("FAIL full_word_one_cycle: valid=%b, required 0", valid_o); end
    endtask

    task automatic test_backpressure();
        logic [DW*R-1:0] w1;
        logic [DW*R-1:0] w2;
        ready_i = 1'b0;
        for (int i = 0; i < R; i++) begin
            @(posedge clk);
            #1 valid_i = 1'b1; data_i = DW'($urandom); w1[i*DW +: DW] = data_i;
        end
        for (int i = 0; i < R - 1; i++) begin
            @(posedge clk);
            #1 data_i = DW'($urandom); w2[i*DW +: DW] = data_i;
            @(negedge clk);
            checks++;
            if (ready_o !== 1'b1) begin failures++; $display("FAIL bp_fill_ready: beat %0d got %b, required 1", i, ready_o); end
        end
        @(posedge clk);
        #1 data_i = DW'($urandom); w2[(R-1)*DW +: DW] = data_i;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o !== w1) begin
                failures++;
                $display("FAIL bp_stall: ready=%b valid=%b data=%h, required 0/1/%h", ready_o, valid_o, data_o, w1);
            end
            @(posedge clk);
            #1;
        end
        ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b, required 1", ready_o); end
        @(posedge clk);
        #1 valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || data_o !== w2) begin
            failures++; $display("FAIL bp_no_bubble: valid=%b data=%h, required 1/%h", valid_o, data_o, w2);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin failures++; $display("FAIL bp_drain: valid=%b, required 0", valid_o); end
    endtask

    task automatic test_throughput();
        int vcyc[$];
        ready_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            valid_i = (c < 16);
            data_i  = DW'($urandom);
            @(negedge clk);
            if (c < 16) begin
                checks++;
                if (ready_o !== 1'b1) begin failures++; $display("FAIL tput_ready: cycle %0d got %b, required 1", c, ready_o); end
            end
            if (valid_o === 1'b1) vcyc.push_back(c);
        end
        valid_i = 1'b0;
        checks++;
        if (vcyc.size() != 4) begin
            failures++; $display("FAIL tput_words: got %0d, required 4", vcyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (vcyc[i] != 4 * (i + 1)) begin
                    failures++; $display("FAIL tput_spacing: word %0d at cycle %0d, required %0d", i, vcyc[i], 4 * (i + 1));
                end
            end
        end
    endtask

`ifdef STREAM_UPSIZER_LAST_EN
    task automatic test_partial();
        ready_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b1; data_i = 8'hAA; last_i = 1'b0;
        @(posedge clk);
        #1 data_i = 8'hBB; last_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0; last_i = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 32'h0000BBAA || strb_o !== 4'h3 || last_o !== 1'b1) begin
            failures++;
            $display("FAIL partial_word: valid=%b data=%h strb=%h last=%b, required 1/0000bbaa/3/1", valid_o, data_o, strb_o, last_o);
        end
        for (int i = 0; i < R; i++) begin
            @(posedge clk);
            #1 valid_i = 1'b1; data_i = DW'($urandom);
        end
        @(posedge clk);
        #1 valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || strb_o !== 4'hF || last_o !== 1'b0) begin
            failures++; $display("FAIL after_partial: valid=%b strb=%h last=%b, required 1/f/0", valid_o, strb_o, last_o);
        end
    endtask

    task automatic test_single_last();
        ready_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b1; data_i = 8'hCC; last_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0; last_i = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 32'h000000CC || strb_o !== 4'h1 || last_o !== 1'b1) begin
            failures++;
            $display("FAIL single_last: valid=%b data=%h strb=%h last=%b, required 1/000000cc/1/1", valid_o, data_o, strb_o, last_o);
        end
        @(posedge clk);
    endtask
`endif

    task automatic test_reset_mid();
        ready_i = 1'b0;
        for (int i = 0; i < R + 2; i++) begin
            @(posedge clk);
            #1 valid_i = 1'b1; data_i = DW'($urandom);
        end
        @(posedge clk);
        #1 valid_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0) begin failures++; $display("FAIL mid_reset_ready: got %b, required 0", ready_o); end
        @(posedge clk);
        #1 rst = 1'b0; ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin failures++; $display("FAIL mid_reset_discard: valid=%b, required 0", valid_o); end
        for (int i = 0; i < R; i++) begin
            @(posedge clk);
            #1 valid_i = 1'b1; data_i = DW'(i + 1);
        end
        @(posedge clk);
        #1 valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 32'h04030201) begin
            failures++; $display("FAIL mid_reset_word: valid=%b data=%h, required 1/04030201", valid_o, data_o);
        end
        @(posedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            valid_i = ($urandom_range(0, 3) != 0);
            data_i  = DW'($urandom);
            ready_i = ($urandom_range(0, 3) != 0);
`ifdef STREAM_UPSIZER_LAST_EN
            last_i  = ($urandom_range(0, 4) == 0);
`endif
            @(negedge clk);
            if (valid_o !== 1'b1) begin
                checks++;
                if (ready_o !== 1'b1) begin failures++; $display("FAIL rand_ready_idle: cycle %0d got %b, required 1", c, ready_o); end
            end
        end
        @(posedge clk);
        #1 valid_i = 1'b0; ready_i = 1'b1;
`ifdef STREAM_UPSIZER_LAST_EN
        last_i = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL rand_drain: %0d words outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_word();
        test_backpressure();
        test_throughput();
`ifdef STREAM_UPSIZER_LAST_EN
        test_partial();
        test_single_last();
`endif
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
